dca_matrix_lsu_rreq_gen: RTL and testbench

- Read-request generator for the DCA matrix load path; sits directly upstream of the read-response formatter.
- Accepts one matrix load instruction and issues one AXI AR burst per matrix row.
- For every burst, pushes a transaction-info record (bit offset, burst length, last-row flag) into an internal FIFO. The formatter pops that record when the burst's last beat is consumed.
- Drives the per-instruction column-valid mask used to pad unused columns.

---
 rtl/dca_matrix_lsu_rreq_gen.sv | 170 +++++++++++++++++
 tb/tb_dca_matrix_lsu_rreq_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_lsu_rreq_gen.sv
// Matrix load read-request generator: one AXI AR burst per matrix row plus a transaction-info FIFO for the response formatter.
// Optional stall statistics counter enabled by defining DCA_MATRIX_LSU_RREQ_STALL_STAT_EN.
module dca_matrix_lsu_rreq_gen #(
    parameter int BW_ADDR        = 32,
    parameter int BW_AXI_DATA    = 128,
    parameter int BW_ELEMENT     = 32,
    parameter int MATRIX_SIZE    = 4,
    parameter int TXN_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inst_valid,
    output logic                           inst_ready,
    input  logic [BW_ADDR-1:0]             inst_addr,
    input  logic [BW_ADDR-1:0]             inst_stride,
    input  logic [$clog2(MATRIX_SIZE)-1:0] inst_num_row_m1,
    input  logic [$clog2(MATRIX_SIZE)-1:0] inst_num_col_m1,
    output logic                           axi_arvalid,
    input  logic                           axi_arready,
    output logic [BW_ADDR-1:0]             axi_araddr,
    output logic [7:0]                     axi_arlen,
    output logic [2:0]                     axi_arsize,
    output logic [1:0]                     axi_arburst,
    output logic                           txn_valid,
    input  logic                           txn_ready,
    output logic [$clog2(BW_AXI_DATA)-1:0] txn_bitaddr,
    output logic [7:0]                     txn_alen,
    output logic                           txn_last_row,
    output logic [MATRIX_SIZE-1:0]         col_mask,
    output logic                           busy,
    output logic                           done
`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
    ,
    output logic [31:0]                    stall_cnt
`endif
);
    localparam int EB     = BW_ELEMENT / 8;
    localparam int BB     = BW_AXI_DATA / 8;
    localparam int LOG_BB = $clog2(BB);
    localparam int RW     = $clog2(MATRIX_SIZE);
    localparam int BA_W   = $clog2(BW_AXI_DATA);
    localparam int PTR_W  = $clog2(TXN_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [BW_ADDR-1:0]   row_addr, stride;
    logic [RW-1:0]        row_cnt, num_row_m1, num_col_m1;
    logic [MATRIX_SIZE-1:0] mask_calc;
    logic [LOG_BB-1:0]    off;
    logic [31:0]          span;
    logic [7:0]           arlen_calc;
    logic [BA_W-1:0]      bitaddr_calc;

    logic [BA_W-1:0]      fifo_bitaddr [TXN_FIFO_DEPTH];
    logic [7:0]           fifo_alen    [TXN_FIFO_DEPTH];
    logic                 fifo_last    [TXN_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_full, fifo_empty, push, pop, accept, last_row;

    // Burst geometry of the current row: the element run starts at off within the first beat.
    assign off          = row_addr[LOG_BB-1:0];
    assign span         = 32'(off) + 32'(num_col_m1) * 32'(EB) + 32'(EB) - 32'd1;
    assign arlen_calc   = 8'(span >> LOG_BB);
    assign bitaddr_calc = {off, 3'b000};

    always_comb begin
        mask_calc = '0;
        for (int i = 0; i < MATRIX_SIZE; i++)
            mask_calc[i] = (i <= int'(inst_num_col_m1));
    end

    assign fifo_full  = (count == CNT_W'(TXN_FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = axi_arvalid & axi_arready;
    assign pop        = txn_ready & ~fifo_empty;
    assign accept     = inst_valid & inst_ready;
    assign last_row   = (row_cnt == num_row_m1);

    always_comb begin
        state_nxt   = state;
        inst_ready  = 1'b0;
        axi_arvalid = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Registered full flag only; a same-cycle pop does not reopen the slot.
                axi_arvalid = ~fifo_full;
                if (~fifo_full && axi_arready && last_row) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && count == CNT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_addr   <= '0;
            row_cnt    <= '0;
            num_row_m1 <= '0;
            num_col_m1 <= '0;
            col_mask   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                row_addr   <= inst_addr;
                row_cnt    <= '0;
                num_row_m1 <= inst_num_row_m1;
                num_col_m1 <= inst_num_col_m1;
                col_mask   <= mask_calc;
            end else if (push) begin
                row_addr <= row_addr + stride;
                row_cnt  <= row_cnt + RW'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) stride <= inst_stride;
        if (push) begin
            fifo_bitaddr[wr_ptr] <= bitaddr_calc;
            fifo_alen[wr_ptr]    <= arlen_calc;
            fifo_last[wr_ptr]    <= last_row;
        end
    end

    assign axi_araddr   = row_addr;
    assign axi_arlen    = arlen_calc;
    assign axi_arsize   = 3'(LOG_BB);
    assign axi_arburst  = 2'b01;
    assign txn_valid    = ~fifo_empty;
    assign txn_bitaddr  = txn_valid ? fifo_bitaddr[rd_ptr] : '0;
    assign txn_alen     = txn_valid ? fifo_alen[rd_ptr] : '0;
    assign txn_last_row = txn_valid ? fifo_last[rd_ptr] : 1'b0;
    assign busy         = (state != IDLE);

`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
    // Counts AR backpressure and FIFO-full cycles while issuing; saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (state == ISSUE && (fifo_full || !axi_arready) && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dca_matrix_lsu_rreq_gen.sv
// Testbench for dca_matrix_lsu_rreq_gen: directed table, hand sequences and randomized instructions vs a row-level model.
module tb_dca_matrix_lsu_rreq_gen;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_addr, inst_stride;
    logic [1:0]  inst_num_row_m1, inst_num_col_m1;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        txn_valid, txn_ready;
    logic [6:0]  txn_bitaddr;
    logic [7:0]  txn_alen;
    logic        txn_last_row;
    logic [3:0]  col_mask;
    logic        busy, done;
`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
    logic [31:0] stall_cnt;
`endif

    dca_matrix_lsu_rreq_gen #(.TXN_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .inst_stride(inst_stride),
        .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_bitaddr(txn_bitaddr), .txn_alen(txn_alen), .txn_last_row(txn_last_row),
        .col_mask(col_mask), .busy(busy), .done(done)
`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Row-level reference: expected bursts of the current instruction, in issue order.
    logic [31:0] m_addr[$];
    int          m_len[$];
    int          m_bit[$];
    bit          m_last[$];
    logic [3:0]  m_mask;
    int          n_rows, ar_issued, popped, occ;
    bit          done_seen;
    logic [31:0] hs_addr[$];
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [6:0]  s_bit;
    logic        s_last;
    logic [3:0]  s_mask;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] stride;
        int          r;
        int          c;
        logic [7:0]  len0;
        logic [6:0]  bit0;
        logic [3:0]  mask;
        logic        last0;
        logic [31:0] addr1;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input logic [31:0] addr, input logic [31:0] stride, input int r, input int c);
        m_addr.delete(); m_len.delete(); m_bit.delete(); m_last.delete(); hs_addr.delete();
        for (int i = 0; i <= r; i++) begin
            logic [31:0] a;
            int          o;
            a = addr + stride * 32'(i);
            o = int'(a % 32'd16);
            m_addr.push_back(a);
            m_len.push_back((o + (c + 1) * 4 - 1) / 16);
            m_bit.push_back(o * 8);
            m_last.push_back(i == r);
        end
        m_mask    = 4'((1 << (c + 1)) - 1);
        n_rows    = r + 1;
        ar_issued = 0;
        popped    = 0;
        occ       = 0;
        done_seen = 1'b0;
    endtask

    task automatic start_inst(input logic [31:0] addr, input logic [31:0] stride, input int r, input int c);
        build_model(addr, stride, r, c);
        @(negedge clk);
        inst_valid      = 1'b1;
        inst_addr       = addr;
        inst_stride     = stride;
        inst_num_row_m1 = 2'(r);
        inst_num_col_m1 = 2'(c);
        axi_arready     = 1'b0;
        txn_ready       = 1'b0;
        #1 chk("inst_ready_idle", 64'(inst_ready), 64'd1);
        @(posedge clk);
        #1 inst_valid = 1'b0;
    endtask

    task automatic step(input bit ar, input bit tr);
        bit exp_done;
        @(negedge clk);
        axi_arready = ar;
        txn_ready   = tr;
        #1;
        exp_done = (ar_issued == n_rows) && (occ == 1) && tr;
        chk("arvalid", 64'(axi_arvalid), 64'((ar_issued < n_rows) && (occ < DEPTH)));
        if (axi_arvalid && ar_issued < n_rows) begin
            chk("araddr", 64'(axi_araddr), 64'(m_addr[ar_issued]));
            chk("arlen", 64'(axi_arlen), 64'(m_len[ar_issued]));
        end
        chk("txn_valid", 64'(txn_valid), 64'(occ > 0));
        if (txn_valid && popped < n_rows) begin
            chk("txn_bitaddr", 64'(txn_bitaddr), 64'(m_bit[popped]));
            chk("txn_alen", 64'(txn_alen), 64'(m_len[popped]));
            chk("txn_last_row", 64'(txn_last_row), 64'(m_last[popped]));
        end
        chk("done", 64'(done), 64'(exp_done));
        chk("busy", 64'(busy), 64'd1);
        chk("inst_ready_busy", 64'(inst_ready), 64'd0);
        chk("col_mask", 64'(col_mask), 64'(m_mask));
        s_araddr = axi_araddr;
        s_arlen  = axi_arlen;
        s_bit    = txn_bitaddr;
        s_last   = txn_last_row;
        s_mask   = col_mask;
        if (axi_arvalid && ar) begin
            hs_addr.push_back(axi_araddr);
            ar_issued++;
            occ++;
        end
        if (txn_valid && tr) begin
            popped++;
            occ--;
        end
        if (done) done_seen = 1'b1;
    endtask

    task automatic finish_inst(input int ar_pct, input int tr_pct);
        int budget = 0;
        while (!done_seen && budget < 300) begin
            step($urandom_range(99) < ar_pct, $urandom_range(99) < tr_pct);
            budget++;
        end
        if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        #1;
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_inst_ready", 64'(inst_ready), 64'd1);
        chk("post_done", 64'(done), 64'd0);
        chk("post_arvalid", 64'(axi_arvalid), 64'd0);
        chk("post_txn_valid", 64'(txn_valid), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_arvalid"}, 64'(axi_arvalid), 64'd0);
        chk({tag, "_txn_valid"}, 64'(txn_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_inst_ready"}, 64'(inst_ready), 64'd1);
        chk({tag, "_col_mask"}, 64'(col_mask), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_araddr"}, 64'(axi_araddr), 64'd0);
        chk({tag, "_arlen"}, 64'(axi_arlen), 64'd0);
        chk({tag, "_txn_bitaddr"}, 64'(txn_bitaddr), 64'd0);
        chk({tag, "_txn_alen"}, 64'(txn_alen), 64'd0);
        chk({tag, "_txn_last_row"}, 64'(txn_last_row), 64'd0);
        chk({tag, "_arsize"}, 64'(axi_arsize), 64'd4);
        chk({tag, "_arburst"}, 64'(axi_arburst), 64'd1);
`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_1000, 32'h40, 3, 3, 8'd0, 7'd0,   4'b1111, 1'b0, 32'h0000_1040};
        tbl[1] = '{32'h0000_100C, 32'h40, 0, 1, 8'd1, 7'd96,  4'b0011, 1'b1, 32'h0};
        tbl[2] = '{32'hFFFF_FFC0, 32'h40, 1, 3, 8'd0, 7'd0,   4'b1111, 1'b0, 32'h0000_0000};
        tbl[3] = '{32'h0000_100F, 32'h10, 2, 3, 8'd1, 7'd120, 4'b1111, 1'b0, 32'h0000_101F};
        tbl[4] = '{32'h0000_1008, 32'h10, 0, 0, 8'd0, 7'd64,  4'b0001, 1'b1, 32'h0};
        tbl[5] = '{32'h0000_1004, 32'h20, 1, 2, 8'd0, 7'd32,  4'b0111, 1'b0, 32'h0000_1024};

        rst = 1'b1;
        inst_valid = 1'b0; inst_addr = '0; inst_stride = '0;
        inst_num_row_m1 = '0; inst_num_col_m1 = '0;
        axi_arready = 1'b0; txn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset");
        @(negedge clk) rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            start_inst(tbl[i].addr, tbl[i].stride, tbl[i].r, tbl[i].c);
            step(1'b1, 1'b1);
            chk("tbl_araddr0", 64'(s_araddr), 64'(tbl[i].addr));
            chk("tbl_arlen0", 64'(s_arlen), 64'(tbl[i].len0));
            chk("tbl_col_mask", 64'(s_mask), 64'(tbl[i].mask));
            step(1'b1, 1'b1);
            chk("tbl_bitaddr0", 64'(s_bit), 64'(tbl[i].bit0));
            chk("tbl_last0", 64'(s_last), 64'(tbl[i].last0));
            if (tbl[i].r > 0) begin
                if (hs_addr.size() > 1) chk("tbl_araddr1", 64'(hs_addr[1]), 64'(tbl[i].addr1));
                else chk("tbl_hs_count", 64'(hs_addr.size()), 64'd2);
            end
            finish_inst(100, 100);
        end

        // Backpressure from the transaction FIFO
        start_inst(32'h0000_3000, 32'h100, 3, 2);
        repeat (5) step(1'b1, 1'b0);
        chk("bp_two_issued", 64'(ar_issued), 64'd2);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("bp_third_issued", 64'(ar_issued), 64'd3);
        repeat (3) step(1'b1, 1'b0);
        chk("bp_no_done", 64'(done_seen), 64'd0);
        finish_inst(100, 100);

        // AR stall on the second row
        start_inst(32'h0000_2000, 32'h10, 1, 3);
        step(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1);
            chk("stall_araddr", 64'(s_araddr), 64'h2010);
            chk("stall_arlen", 64'(s_arlen), 64'd0);
        end
        step(1'b1, 1'b1);
        chk("stall_issued", 64'(ar_issued), 64'd2);
        @(negedge clk);
        #1;
`ifdef DCA_MATRIX_LSU_RREQ_STALL_STAT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        done_seen = done_seen | done;
        if (done) begin
            popped++;
            occ--;
        end
        finish_inst(100, 100);

        // Reset in the middle of issuing
        start_inst(32'h0000_4000, 32'h40, 3, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_two_issued", 64'(ar_issued), 64'd2);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check_reset_state("midrst");
        @(negedge clk) rst = 1'b0;
        start_inst(32'h0000_5004, 32'h40, 2, 3);
        finish_inst(80, 80);

        // Randomized instructions
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a, s;
            a = $urandom;
            s = ($urandom_range(1) == 1) ? 32'($urandom) : 32'($urandom_range(64));
            start_inst(a, s, int'($urandom_range(3)), int'($urandom_range(3)));
            finish_inst(70, 60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
